// File: rtl/bin2bcd_pkg.sv
// bin2bcd_pkg
// Shared types and elaboration helpers for the sequential binary-to-BCD
// converter (bin2bcd_seq).
//   state_t       - converter sequencing states
//   digits_needed - decimal digits required to show any BIN_W-bit value
//   cnt_width     - width of the shift counter for a given operand width
package bin2bcd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // ceil(bin_w * log10(2)), using log10(2) ~= 0.30103 in fixed point.
  // The product never lands on an integer, so rounding up is exact here.
  function automatic int digits_needed(input int bin_w);
    return (bin_w * 30103 + 99999) / 100000;
  endfunction

  // The counter must be able to represent BIN_W itself.
  function automatic int cnt_width(input int bin_w);
    return $clog2(bin_w + 1);
  endfunction

endpackage

// File: rtl/bin2bcd_if.sv
// bin2bcd_if
// Operand and result handshake bundle for bin2bcd_seq.
//   in_valid/in_ready/binary        - operand channel (producer -> converter)
//   out_valid/out_ready/bcd/blank/ovf - result channel (converter -> consumer)
// Modports:
//   master - the producer/consumer side driving operands and taking results
//   slave  - the converter itself
interface bin2bcd_if #(
  parameter int BIN_W  = 8,
  parameter int DIGITS = 3
);

  logic                  in_valid;
  logic                  in_ready;
  logic [BIN_W-1:0]      binary;
  logic                  out_valid;
  logic                  out_ready;
  logic [4*DIGITS-1:0]   bcd;
  logic [DIGITS-1:0]     blank;
  logic                  ovf;

  modport master (
    output in_valid,
    output binary,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  bcd,
    input  blank,
    input  ovf
  );

  modport slave (
    input  in_valid,
    input  binary,
    input  out_ready,
    output in_ready,
    output out_valid,
    output bcd,
    output blank,
    output ovf
  );

endinterface

// File: rtl/bcd_digit_adj.sv
// bcd_digit_adj
// Combinational double-dabble correction for one BCD digit: a digit of 5 or
// more gets 3 added (4-bit wrap) so that the following left shift carries
// correctly into the next decimal digit.
//   din  - current digit
//   dout - corrected digit, ready to be shifted
module bcd_digit_adj (
  input  logic [3:0] din,
  output logic [3:0] dout
);

  always_comb begin
    dout = din;
    if (din >= 4'd5) begin
      dout = din + 4'd3;
    end
  end

endmodule

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq
// Sequential binary-to-BCD converter (shift-and-add-3), one operand bit per
// clock. An operand is accepted in IDLE, shifted for BIN_W cycles, and the
// result is then held in DONE until the consumer takes it.
//   clk - rising-edge clock
//   rst - asynchronous reset, active-high
//   bus - bin2bcd_if slave: in_valid/in_ready/binary in, out_valid/out_ready,
//         bcd (digit 0 = units), blank (leading-zero mask), ovf (value did not
//         fit in DIGITS digits; bcd then holds value mod 10^DIGITS)
// WARN_NARROW flags, at elaboration, a DIGITS too small for BIN_W; an
// instance that relies on the mod-10^DIGITS wrap on purpose can clear it.
module bin2bcd_seq
  import bin2bcd_pkg::*;
#(
  parameter int BIN_W       = 8,
  parameter int DIGITS      = 3,
  parameter bit WARN_NARROW = 1'b1
) (
  input  logic     clk,
  input  logic     rst,
  bin2bcd_if.slave bus
);

  localparam int CNT_W = cnt_width(BIN_W);
  localparam int DIG_W = 4 * DIGITS;

  if (BIN_W < 1) begin : g_bad_bin_w
    $error("bin2bcd_seq: BIN_W must be at least 1 (got %0d)", BIN_W);
  end

  if (DIGITS < 1) begin : g_bad_digits
    $error("bin2bcd_seq: DIGITS must be at least 1 (got %0d)", DIGITS);
  end

  if (WARN_NARROW && (DIGITS < digits_needed(BIN_W))) begin : g_narrow
    $warning("bin2bcd_seq: DIGITS=%0d is below the %0d needed for BIN_W=%0d; large values wrap and set ovf",
             DIGITS, digits_needed(BIN_W), BIN_W);
  end

  state_t             state_q;
  state_t             state_d;
  logic [BIN_W-1:0]   operand_q;
  logic [DIG_W-1:0]   digits_q;
  logic [DIG_W-1:0]   digits_adj;
  logic [DIG_W-1:0]   digits_shift;
  logic [CNT_W-1:0]   cnt_q;
  logic               ovf_acc_q;
  logic               ovf_shift;
  logic [DIG_W-1:0]   bcd_q;
  logic [DIGITS-1:0]  blank_q;
  logic [DIGITS-1:0]  blank_d;
  logic [DIGITS-1:0]  nz_d;
  logic               ovf_q;
  logic               accept;
  logic               shift_en;
  logic               last_shift;

  assign accept     = (state_q == IDLE) && bus.in_valid;
  assign shift_en   = (state_q == SHIFT);
  assign last_shift = shift_en && (cnt_q == CNT_W'(BIN_W - 1));

  // One correction cell per digit; all digits are corrected before the shift.
  for (genvar d = 0; d < DIGITS; d++) begin : g_adj
    bcd_digit_adj u_adj (
      .din  (digits_q[4*d +: 4]),
      .dout (digits_adj[4*d +: 4])
    );
  end

  // The operand MSB enters the units digit; the bit leaving the top digit
  // means the value has grown past 10^DIGITS.
  assign digits_shift = {digits_adj[DIG_W-2:0], operand_q[BIN_W-1]};
  assign ovf_shift    = digits_adj[DIG_W-1];

  // A digit is blanked when it and every digit above it are zero. The units
  // digit always shows, so a zero result reads "0".
  always_comb begin
    nz_d    = '0;
    blank_d = '0;
    for (int d = 0; d < DIGITS; d++) begin
      nz_d[d] = |digits_shift[4*d +: 4];
    end
    for (int d = 0; d < DIGITS; d++) begin
      blank_d[d] = ((nz_d >> d) == '0);
    end
    blank_d[0] = 1'b0;
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and handshake outputs, decoded from the registered state only.
  always_comb begin
    state_d       = state_q;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    case (state_q)
      IDLE: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) begin
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (last_shift) begin
          state_d = DONE;
        end
      end
      DONE: begin
        bus.out_valid = 1'b1;
        if (bus.out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Datapath. The result registers are only written on the final shift, so
  // a partial conversion never reaches the outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      operand_q <= '0;
      digits_q  <= '0;
      cnt_q     <= '0;
      ovf_acc_q <= 1'b0;
      bcd_q     <= '0;
      blank_q   <= '0;
      ovf_q     <= 1'b0;
    end else if (accept) begin
      operand_q <= bus.binary;
      digits_q  <= '0;
      cnt_q     <= '0;
      ovf_acc_q <= 1'b0;
      bcd_q     <= '0;
      blank_q   <= '0;
      ovf_q     <= 1'b0;
    end else if (shift_en) begin
      operand_q <= operand_q << 1;
      digits_q  <= digits_shift;
      cnt_q     <= cnt_q + CNT_W'(1);
      ovf_acc_q <= ovf_acc_q | ovf_shift;
      if (last_shift) begin
        bcd_q   <= digits_shift;
        blank_q <= blank_d;
        ovf_q   <= ovf_acc_q | ovf_shift;
      end
    end
  end

  assign bus.bcd   = bcd_q;
  assign bus.blank = blank_q;
  assign bus.ovf   = ovf_q;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// tb_bin2bcd_seq
// Drives five converter instances of different widths from one shared set of
// stimulus signals (only the selected instance sees valid/ready) and checks
// every result against a decimal-arithmetic reference model.
module tb_bin2bcd_seq;

  // Instance geometry: index -> {BIN_W, DIGITS}. Index 3 is deliberately
  // too narrow so that ovf can be exercised.
  localparam logic [4:0][7:0] BWS = {8'd16, 8'd8, 8'd8, 8'd5, 8'd1};
  localparam logic [4:0][7:0] DGS = {8'd5,  8'd2, 8'd3, 8'd2, 8'd1};

  logic        clk = 1'b0;
  logic        rst;
  int          sel;
  logic        in_valid;
  logic [15:0] binary;
  logic        out_ready;

  logic        o_ir    [5];
  logic        o_ov    [5];
  logic [19:0] o_bcd   [5];
  logic [4:0]  o_blank [5];
  logic        o_ovf   [5];

  int          nchecks = 0;
  int          nerr    = 0;
  int          exp_q[$];
  logic [19:0] last_bcd;

  always #5 clk = ~clk;

  for (genvar k = 0; k < 5; k++) begin : g_dut
    localparam int BW = int'(BWS[k]);
    localparam int DG = int'(DGS[k]);

    bin2bcd_if #(.BIN_W(BW), .DIGITS(DG)) bus ();

    assign bus.in_valid  = in_valid && (sel == k);
    assign bus.binary    = binary[BW-1:0];
    assign bus.out_ready = out_ready && (sel == k);
    assign o_ir[k]       = bus.in_ready;
    assign o_ov[k]       = bus.out_valid;
    assign o_bcd[k]      = 20'(bus.bcd);
    assign o_blank[k]    = 5'(bus.blank);
    assign o_ovf[k]      = bus.ovf;

    bin2bcd_seq #(.BIN_W(BW), .DIGITS(DG), .WARN_NARROW(k != 3)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
    );
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  // Reference model: plain decimal arithmetic on the operand value.
  function automatic void model(input int k, input longint v, output logic [19:0] eb,
                                output logic [4:0] ebl, output logic eo);
    longint lim = 1;
    longint m;
    int     nd  = int'(DGS[k]);
    for (int d = 0; d < nd; d++) lim = lim * 10;
    eo  = (v >= lim);
    m   = v % lim;
    eb  = '0;
    ebl = '0;
    for (int d = 0; d < nd; d++) begin
      longint p = 1;
      for (int j = 0; j < d; j++) p = p * 10;
      eb[4*d +: 4] = 4'((m / p) % 10);
      ebl[d]       = (d > 0) && (m < p);
    end
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchecks++;
    assert (obs === exp) else begin
      nerr++;
      $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Called at a falling edge; returns at the falling edge after the accept.
  task automatic applyStimulus(input int k, input int v);
    int t = 0;
    sel       = k;
    binary    = 16'(v);
    in_valid  = 1'b1;
    out_ready = 1'b0;
    while (!o_ir[k] && t < 40) begin
      @(negedge clk);
      t++;
    end
    checkOutput("in_ready before accept", 32'(o_ir[k]), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    binary   = 16'($urandom);
    exp_q.push_back(v);
  endtask

  // Waits for out_valid while throwing ignored traffic at the block, then
  // checks latency and the result against the model.
  task automatic checkResult(input int k, input string tag);
    int          cyc = 0;
    int          v;
    logic [19:0] eb;
    logic [4:0]  ebl;
    logic        eo;
    while (!o_ov[k] && cyc < 40) begin
      out_ready = 1'($urandom_range(0, 1));
      in_valid  = 1'($urandom_range(0, 1));
      binary    = 16'($urandom);
      @(negedge clk);
      cyc++;
    end
    out_ready = 1'b0;
    in_valid  = 1'b0;
    checkOutput({tag, " latency"}, 32'(cyc), 32'(BWS[k]));
    if (exp_q.size() == 0) begin
      checkOutput({tag, " scoreboard has operand"}, 32'd0, 32'd1);
      v = 0;
    end else begin
      v = exp_q.pop_front();
    end
    model(k, longint'(v), eb, ebl, eo);
    last_bcd = eb;
    checkOutput({tag, " bcd"},   32'(o_bcd[k]),   32'(eb));
    checkOutput({tag, " blank"}, 32'(o_blank[k]), 32'(ebl));
    checkOutput({tag, " ovf"},   32'(o_ovf[k]),   32'(eo));
    checkOutput({tag, " in_ready in DONE"}, 32'(o_ir[k]), 32'd0);
  endtask

  // Holds the result for 'hold' cycles under ignored in_valid pulses, then
  // takes it and expects exactly one handshake.
  task automatic releaseResult(input int k, input int hold, input string tag);
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'($urandom_range(0, 1));
      binary   = 16'($urandom);
      @(negedge clk);
      checkOutput({tag, " held bcd"},       32'(o_bcd[k]), 32'(last_bcd));
      checkOutput({tag, " held out_valid"}, 32'(o_ov[k]),  32'd1);
      checkOutput({tag, " held in_ready"},  32'(o_ir[k]),  32'd0);
    end
    out_ready = 1'b1;
    in_valid  = 1'($urandom_range(0, 1));
    @(negedge clk);
    out_ready = 1'b0;
    in_valid  = 1'b0;
    checkOutput({tag, " in_ready after take"},  32'(o_ir[k]), 32'd1);
    checkOutput({tag, " out_valid after take"}, 32'(o_ov[k]), 32'd0);
  endtask

  initial begin
    int k;
    int v;
    rst       = 1'b1;
    sel       = 0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    binary    = '0;
    repeat (2) @(negedge clk);

    $display("[TB] reset state");
    checkOutput("reset in_ready",  32'(o_ir[2]),  32'd1);
    checkOutput("reset out_valid", 32'(o_ov[2]),  32'd0);
    checkOutput("reset bcd",       32'(o_bcd[2]), 32'd0);
    checkOutput("reset ovf",       32'(o_ovf[2]), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    $display("[TB] 5-bit / 2-digit exhaustive");
    for (int i = 0; i < 32; i++) begin
      applyStimulus(1, i);
      checkResult(1, "w5");
      if (i == 31) begin
        checkOutput("w5 31 bcd",   32'(o_bcd[1]),   32'h31);
        checkOutput("w5 31 blank", 32'(o_blank[1]), 32'b00);
      end
      releaseResult(1, 0, "w5");
    end

    $display("[TB] 8-bit / 3-digit directed");
    applyStimulus(2, 255);
    checkResult(2, "w8 255");
    checkOutput("w8 255 bcd const",   32'(o_bcd[2]),   32'h255);
    checkOutput("w8 255 blank const", 32'(o_blank[2]), 32'b000);
    releaseResult(2, 0, "w8 255");
    applyStimulus(2, 7);
    checkResult(2, "w8 7");
    checkOutput("w8 7 bcd const",   32'(o_bcd[2]),   32'h007);
    checkOutput("w8 7 blank const", 32'(o_blank[2]), 32'b110);
    releaseResult(2, 0, "w8 7");
    applyStimulus(2, 0);
    checkResult(2, "w8 0");
    checkOutput("w8 0 bcd const",   32'(o_bcd[2]),   32'h000);
    checkOutput("w8 0 blank const", 32'(o_blank[2]), 32'b110);
    releaseResult(2, 0, "w8 0");

    $display("[TB] 8-bit / 2-digit overflow");
    applyStimulus(3, 200);
    checkResult(3, "ovf 200");
    checkOutput("ovf 200 bcd const", 32'(o_bcd[3]), 32'h00);
    checkOutput("ovf 200 ovf const", 32'(o_ovf[3]), 32'd1);
    releaseResult(3, 0, "ovf 200");
    applyStimulus(3, 99);
    checkResult(3, "ovf 99");
    checkOutput("ovf 99 bcd const", 32'(o_bcd[3]), 32'h99);
    checkOutput("ovf 99 ovf const", 32'(o_ovf[3]), 32'd0);
    releaseResult(3, 0, "ovf 99");

    $display("[TB] back-pressure");
    applyStimulus(2, 123);
    checkResult(2, "bp 123");
    checkOutput("bp 123 bcd const", 32'(o_bcd[2]), 32'h123);
    releaseResult(2, 10, "bp 123");

    $display("[TB] reset during shift");
    applyStimulus(2, 200);
    void'(exp_q.pop_back());
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("mid-reset in_ready",  32'(o_ir[2]),    32'd1);
    checkOutput("mid-reset out_valid", 32'(o_ov[2]),    32'd0);
    checkOutput("mid-reset bcd",       32'(o_bcd[2]),   32'd0);
    checkOutput("mid-reset blank",     32'(o_blank[2]), 32'd0);
    @(negedge clk);
    applyStimulus(2, 42);
    checkResult(2, "after reset 42");
    checkOutput("after reset 42 bcd const", 32'(o_bcd[2]), 32'h042);
    releaseResult(2, 0, "after reset 42");

    $display("[TB] random traffic");
    for (int n = 0; n < 150; n++) begin
      case ($urandom_range(0, 3))
        0:       k = 0;
        1:       k = 1;
        2:       k = 2;
        default: k = 4;
      endcase
      v = int'($urandom & ((32'd1 << BWS[k]) - 32'd1));
      repeat ($urandom_range(0, 2)) @(negedge clk);
      applyStimulus(k, v);
      checkResult(k, "rand");
      releaseResult(k, int'($urandom_range(0, 3)), "rand");
    end

    checkOutput("scoreboard empty", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
    $finish;
  end

endmodule
